// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared states, tile count and tile-offset helper for the loader sequencer
package sa_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    FLOAD = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam int NUM_TILES = 4;
  function automatic int tile_off(input logic [1:0] tile, input int stride);
    return (tile[1] ? stride : 0) + int'(tile[0]);
  endfunction
endpackage

// File: rtl/sa_ctrl_watchdog.sv
// sa_ctrl_watchdog: per-phase cycle counter with expiry and done-guard indication
module sa_ctrl_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire,
  output logic armed
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // count cycles spent in a load phase, restarting on every state entry
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = en && cnt == CW'(TIMEOUT - 1);
  assign armed  = cnt != '0;
endmodule

// File: rtl/sa_loader_ctrl.sv
// sa_loader_ctrl: sequences weight preload and four feature-tile passes of the 2x2 systolic loader
module sa_loader_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int ROW_STRIDE = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              skip_wl_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] feat_base_i,
  input  logic              is_WL_done_i,
  input  logic              is_FL_done_i,
  input  logic [7:0]        c11_i,
  input  logic [7:0]        c12_i,
  input  logic [7:0]        c21_i,
  input  logic [7:0]        c22_i,
  output logic              Weight_Preloader_en_o,
  output logic              Feature_Loader_en_o,
  output logic              mode_o,
  output logic [ADDR_W-1:0] feature_baseaddr_o,
  output logic [2:0]        c_sel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       result_o
);
  state_t state, nxt;
  logic [1:0] tile, tile_n;
  logic [ADDR_W-1:0] base, base_n;
  logic err_n, expire, armed, last;
  assign last = tile == 2'(NUM_TILES - 1);
  sa_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (nxt != state),
    .en     (state == WLOAD || state == FLOAD),
    .expire (expire),
    .armed  (armed)
  );
  // next state, tile/base bookkeeping and sticky error; abort beats done, done beats timeout
  always_comb begin
    nxt    = state;
    tile_n = tile;
    base_n = base;
    err_n  = err_o;
    unique case (state)
      IDLE: if (start_i) begin
        nxt    = skip_wl_i ? FLOAD : WLOAD;
        tile_n = '0;
        base_n = feat_base_i;
        err_n  = 1'b0;
      end
      WLOAD:
        if (abort_i) nxt = IDLE;
        else if (armed && is_WL_done_i) nxt = FLOAD;
        else if (expire) begin
          nxt   = IDLE;
          err_n = 1'b1;
        end
      FLOAD:
        if (abort_i) nxt = IDLE;
        else if (armed && is_FL_done_i) begin
          nxt    = last ? DONE : GAP;
          tile_n = last ? tile : tile + 2'd1;
        end else if (expire) begin
          nxt   = IDLE;
          err_n = 1'b1;
        end
      GAP:     nxt = abort_i ? IDLE : FLOAD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state plus outputs registered from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state                 <= IDLE;
      tile                  <= '0;
      base                  <= '0;
      err_o                 <= 1'b0;
      Weight_Preloader_en_o <= 1'b0;
      Feature_Loader_en_o   <= 1'b0;
      mode_o                <= 1'b0;
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      feature_baseaddr_o    <= '0;
      c_sel_o               <= '0;
      result_o              <= '0;
    end else begin
      state                 <= nxt;
      tile                  <= tile_n;
      base                  <= base_n;
      err_o                 <= err_n;
      Weight_Preloader_en_o <= nxt == WLOAD;
      Feature_Loader_en_o   <= nxt == FLOAD;
      mode_o                <= nxt == FLOAD || nxt == GAP;
      busy_o                <= nxt != IDLE;
      done_o                <= state == DONE && !abort_i;
      feature_baseaddr_o    <= base_n + ADDR_W'(tile_off(tile_n, ROW_STRIDE));
      c_sel_o               <= {1'b0, tile_n};
      if (state == DONE && !abort_i) result_o <= {c11_i, c12_i, c21_i, c22_i};
    end
endmodule

// File: tb/tb_sa_loader_ctrl.sv
// tb_sa_loader_ctrl: directed scenarios for the systolic loader sequencer
module tb_sa_loader_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, skip = 1'b0, abort = 1'b0;
  logic [5:0] fbase = '0;
  logic wl_man = 1'b0, fl_man = 1'b0, auto_ld = 1'b0;
  logic [7:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
  logic wen, fen, mode, busy, done, err, wl_done, fl_done;
  logic [5:0] addr;
  logic [2:0] csel;
  logic [31:0] result;
  int checks = 0, errors = 0;
  int fcnt = 0, wcnt = 0;
  int nt, gaps, dones, wseen, gapbad;
  int rl[4];
  logic [5:0] ta[4];
  logic [2:0] tc[4];
  logic hung;

  sa_loader_ctrl #(.ADDR_W(6), .ROW_STRIDE(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .skip_wl_i(skip), .abort_i(abort),
    .feat_base_i(fbase), .is_WL_done_i(wl_done), .is_FL_done_i(fl_done),
    .c11_i(c11), .c12_i(c12), .c21_i(c21), .c22_i(c22),
    .Weight_Preloader_en_o(wen), .Feature_Loader_en_o(fen), .mode_o(mode),
    .feature_baseaddr_o(addr), .c_sel_o(csel), .busy_o(busy), .done_o(done),
    .err_o(err), .result_o(result)
  );

  always #5 clk = ~clk;

  // loader model: done level rises once the enable has been held for 5 cycles
  always @(posedge clk) begin
    fcnt <= fen ? fcnt + 1 : 0;
    wcnt <= wen ? wcnt + 1 : 0;
  end
  assign fl_done = auto_ld ? (fcnt >= 5) : fl_man;
  assign wl_done = auto_ld ? (wcnt >= 5) : wl_man;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [5:0] b, input logic s);
    start = 1'b1; skip = s; fbase = b;
    step();
    start = 1'b0; skip = 1'b0;
  endtask

  task automatic collect;
    logic pf;
    pf = 1'b0; nt = 0; gaps = 0; dones = 0; wseen = 0; gapbad = 0; hung = 1'b1;
    rl = '{default: 0};
    for (int i = 0; i < 400; i++) begin
      if (fen && !pf && nt < 4) begin ta[nt] = addr; tc[nt] = csel; nt++; end
      if (fen && nt > 0) rl[nt-1]++;
      if (busy && !fen && nt >= 1 && nt < 4) begin gaps++; if (!mode) gapbad++; end
      wseen += int'(wen);
      dones += int'(done);
      pf = fen;
      if (!busy) begin hung = 1'b0; break; end
      step();
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({wen, fen, mode, busy, done, err, addr, csel, result} !== 47'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {wen, fen, mode, busy, done, err, addr, csel, result});
    end
    @(negedge clk) rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %0b exp 0", busy); end
  endtask

  task automatic test_normal;
    logic [5:0] ea[4];
    ea = '{6'd9, 6'd10, 6'd13, 6'd14};
    c11 = 8'hA1; c12 = 8'hB2; c21 = 8'hC3; c22 = 8'hD4;
    auto_ld = 1'b1;
    start_seq(6'd9, 1'b0);
    checks++;
    if ({wen, fen, mode, busy} !== 4'b1001) begin
      errors++; $display("FAIL normal_first_enable got %b exp 1001", {wen, fen, mode, busy});
    end
    collect();
    checks++;
    if (hung) begin errors++; $display("FAIL normal_hang busy got 1 exp 0"); end
    checks++;
    if (nt !== 4) begin errors++; $display("FAIL normal_tiles got %0d exp 4", nt); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ta[k] !== ea[k] || tc[k] !== 3'(k)) begin
        errors++; $display("FAIL normal_tile%0d addr/csel got %0d/%0d exp %0d/%0d", k, ta[k], tc[k], ea[k], k);
      end
    end
    checks++;
    if (gaps !== 3 || gapbad !== 0) begin
      errors++; $display("FAIL normal_gaps got %0d (mode0 %0d) exp 3 (0)", gaps, gapbad);
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL normal_done_count got %0d exp 1", dones); end
    checks++;
    if (result !== 32'hA1B2C3D4) begin errors++; $display("FAIL normal_result got %h exp a1b2c3d4", result); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL normal_err got %0b exp 0", err); end
    step();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL normal_done_pulse got %0b exp 0", done); end
  endtask

  task automatic test_skip;
    auto_ld = 1'b1;
    start_seq(6'd20, 1'b1);
    checks++;
    if ({wen, fen, mode, addr, csel} !== {3'b011, 6'd20, 3'd0}) begin
      errors++; $display("FAIL skip_first_enable got %b/%0d/%0d exp 011/20/0", {wen, fen, mode}, addr, csel);
    end
    collect();
    checks++;
    if (wseen !== 0 || hung) begin errors++; $display("FAIL skip_weight_en got %0d (hung %0b) exp 0", wseen, hung); end
    checks++;
    if (nt !== 4 || ta[3] !== 6'd25 || dones !== 1) begin
      errors++; $display("FAIL skip_run tiles/addr3/done got %0d/%0d/%0d exp 4/25/1", nt, ta[3], dones);
    end
  endtask

  task automatic test_wrap;
    logic [5:0] ea[4];
    ea = '{6'd62, 6'd63, 6'd2, 6'd3};
    auto_ld = 1'b1;
    start_seq(6'd62, 1'b1);
    collect();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ta[k] !== ea[k]) begin errors++; $display("FAIL wrap_tile%0d addr got %0d exp %0d", k, ta[k], ea[k]); end
    end
  endtask

  task automatic test_stuck_done;
    c11 = 8'h01; c12 = 8'h02; c21 = 8'h03; c22 = 8'h04;
    auto_ld = 1'b0; fl_man = 1'b1;
    start_seq(6'd0, 1'b1);
    collect();
    fl_man = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rl[k] < 2 || tc[k] !== 3'(k)) begin
        errors++; $display("FAIL stuck_tile%0d len/csel got %0d/%0d exp >=2/%0d", k, rl[k], tc[k], k);
      end
    end
    checks++;
    if (dones !== 1 || result !== 32'h01020304) begin
      errors++; $display("FAIL stuck_done done/result got %0d/%h exp 1/01020304", dones, result);
    end
  endtask

  task automatic test_timeout;
    auto_ld = 1'b0; wl_man = 1'b0;
    c11 = 8'hEE;
    start_seq(6'd5, 1'b0);
    collect();
    checks++;
    if (wseen !== 8) begin errors++; $display("FAIL timeout_cycles got %0d exp 8", wseen); end
    checks++;
    if ({err, busy} !== 2'b10 || dones !== 0) begin
      errors++; $display("FAIL timeout_flags err/busy/done got %0b/%0b/%0d exp 1/0/0", err, busy, dones);
    end
    checks++;
    if (result !== 32'h01020304) begin errors++; $display("FAIL timeout_result got %h exp 01020304", result); end
    c11 = 8'h01;
    auto_ld = 1'b1;
    start_seq(6'd0, 1'b1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got %0b exp 0", err); end
    collect();
  endtask

  task automatic test_abort_reset;
    logic found;
    c11 = 8'h55; c12 = 8'h55; c21 = 8'h55; c22 = 8'h55;
    auto_ld = 1'b1;
    start_seq(6'd0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (fen && csel == 3'd2) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach_tile2 got 0 exp 1"); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, fen, wen, done, err} !== 5'b0) begin
      errors++; $display("FAIL abort_idle busy/fen/wen/done/err got %b exp 00000", {busy, fen, wen, done, err});
    end
    checks++;
    if (result !== 32'h01020304) begin errors++; $display("FAIL abort_result got %h exp 01020304", result); end
    abort = 1'b1; start = 1'b1; skip = 1'b1;
    step();
    abort = 1'b0; start = 1'b0; skip = 1'b0;
    checks++;
    if ({busy, fen} !== 2'b11) begin errors++; $display("FAIL abort_start_wins got %b exp 11", {busy, fen}); end
    collect();
    checks++;
    if (result !== 32'h55555555 || dones !== 1) begin
      errors++; $display("FAIL abort_rerun result/done got %h/%0d exp 55555555/1", result, dones);
    end
    start_seq(6'd7, 1'b1);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wen, fen, mode, busy, done, err, addr, csel, result} !== 47'd0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {wen, fen, mode, busy, done, err, addr, csel, result});
    end
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_skip();
    test_wrap();
    test_stuck_done();
    test_timeout();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_loader_ctrl.md
Name: sa_loader_ctrl

Overview:
Sequencer for the 2x2 systolic-array loader (top_sa_loader). On a single start pulse it runs the weight preload (mode 0) and then four feature-load passes (mode 1). Each pass covers one 2x2 output tile, using base + {0, 1, ROW_STRIDE, ROW_STRIDE+1} and c_sel 0..3. At the end it captures c11..c22 and reports done, with a per-phase watchdog and an abort path.

Parameters:
ADDR_W, 6, width of feature_baseaddr
ROW_STRIDE, 4, feature-map row pitch in words; tile offsets are 0, 1, ROW_STRIDE, ROW_STRIDE+1
TIMEOUT, 255, maximum cycles per load phase before error; TIMEOUT >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start_i  in  1  begin a sequence; sampled only in IDLE
skip_wl_i  in  1  sampled with start_i; 1 = weights already resident, skip preload
abort_i  in  1  terminate the current sequence
feat_base_i  in  ADDR_W  feature window base; latched at start
is_WL_done_i  in  1  weight-preload done from the loader (level)
is_FL_done_i  in  1  feature-load done from the loader (level)
c11_i, c12_i, c21_i, c22_i  in  8 each  loader result outputs
Weight_Preloader_en_o  out  1  weight loader enable
Feature_Loader_en_o  out  1  feature loader enable
mode_o  out  1  0 = weight load, 1 = feature load
feature_baseaddr_o  out  ADDR_W  current tile base address
c_sel_o  out  3  tile index; MSB always 0
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse on successful completion
err_o  out  1  sticky watchdog error; cleared by the next accepted start
result_o  out  32  {c11, c12, c21, c22} captured at completion

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including result_o and err_o; tile index, watchdog and latched base are 0.
- All outputs are registered. Transitions occur on the rising clk edge.
- States: IDLE, WLOAD, FLOAD, GAP, DONE.
- IDLE:
  - start_i=1 latches feat_base_i, sets tile=0 and clears err_o.
  - Next state is FLOAD if skip_wl_i=1, otherwise WLOAD. Latency from start to the first enable is 1 cycle.
- WLOAD: Weight_Preloader_en_o=1, mode_o=0. is_WL_done_i=1 sampled -> FLOAD.
- FLOAD:
  - Outputs: Feature_Loader_en_o=1, mode_o=1, c_sel_o=tile.
  - feature_baseaddr_o = (base + off[tile]) mod 2^ADDR_W; wrap is silent.
  - is_FL_done_i=1 with tile<3 -> GAP. With tile==3 -> DONE.
- GAP:
  - Exactly 1 cycle with Feature_Loader_en_o=0, which retriggers the loader.
  - tile increments; address and c_sel update this cycle. mode_o stays 1.
  - Next state FLOAD.
- DONE:
  - 1 cycle, all enables 0.
  - At the exiting edge, result_o <= {c11_i, c12_i, c21_i, c22_i}.
  - done_o is high during the following IDLE cycle; result_o is valid from that cycle onward.
- Done guard: in WLOAD/FLOAD, a done input is honoured only from the 2nd cycle in the state onward. This prevents a stale level from the previous pass being taken as completion.
- Watchdog:
  - Counter clears on every state entry and increments in WLOAD/FLOAD.
  - Reaching TIMEOUT without done: err_o=1, next state IDLE, no done_o, result_o unchanged.
- abort_i=1 in any non-IDLE state:
  - Next state IDLE, enables 0, no done_o, err_o unchanged.
  - abort_i has priority over a done input in the same cycle.
  - abort_i in IDLE is ignored; abort_i together with start_i in IDLE -> start wins.
- start_i while busy_o=1 is ignored.
- done and timeout in the same cycle: done wins.

Decomposition:
- Package sa_ctrl_pkg holds:
  - state enum: IDLE=0, WLOAD=1, FLOAD=2, GAP=3, DONE=4
  - tile-offset function over ROW_STRIDE
  - NUM_TILES=4
- One sub-module, sa_ctrl_watchdog: clear/enable inputs, TIMEOUT parameter, expire output.
- The FSM, address generation and result capture stay in sa_loader_ctrl.

Test Plan:
1. Normal run: base=6'd9, skip_wl=0, loader model asserts done 5 cycles after each enable -> addresses 9, 10, 13, 14 with c_sel 0..3; one GAP cycle with Feature_Loader_en_o=0 between tiles; done_o pulses once; result_o equals the c inputs presented in DONE; err_o=0.
2. Skip weights: start with skip_wl=1 -> Weight_Preloader_en_o never asserts; first enable is Feature_Loader_en_o, 1 cycle after start.
3. Wrap-around: base=6'd62 -> addresses 62, 63, 2, 3.
4. Stuck done level: hold is_FL_done_i=1 continuously -> each FLOAD still lasts at least 2 cycles; the 4 tiles complete in order.
5. Timeout: is_WL_done_i held 0 with TIMEOUT=8 -> after 8 WLOAD cycles err_o=1, busy_o=0, no done_o; the next start clears err_o.
6. Abort and reset mid-run: abort_i during tile 2 -> IDLE next cycle, enables 0, no done_o, result_o unchanged. Separately, rst low mid-FLOAD -> all outputs 0 immediately, without waiting for a clock edge.
